// File: rtl/ads8864_adc_ctrl_if.sv
// -----------------------------------------------------------------------------
// ads8864_adc_ctrl_if
// Pin-level bundle of the ADS8864 3-wire serial link.
//   ADC_CNVST : conversion start, initiator -> ADC
//   ADC_SCLK  : serial clock, initiator -> ADC, idles low
//   ADC_SDOUT : serial data, ADC -> initiator, MSB first
// Modports:
//   master : the controller (drives CNVST/SCLK, reads SDOUT)
//   slave  : the ADC or an ADC model (reads CNVST/SCLK, drives SDOUT)
// -----------------------------------------------------------------------------
interface ads8864_adc_ctrl_if;
   logic ADC_CNVST;
   logic ADC_SCLK;
   logic ADC_SDOUT;

   modport master (
      output ADC_CNVST,
      output ADC_SCLK,
      input  ADC_SDOUT
   );

   modport slave (
      input  ADC_CNVST,
      input  ADC_SCLK,
      output ADC_SDOUT
   );
endinterface

// File: rtl/ads8864_adc_ctrl.sv
// -----------------------------------------------------------------------------
// ads8864_adc_ctrl
// Initiator side of the ADS8864 serial link. Launches a conversion with
// ADC_CNVST, waits for it to finish, clocks NBITS+1 bits in on ADC_SCLK
// (leading indicator bit + sample) and presents the sample on DATA with a
// one-cycle DATA_VALID strobe. Single-shot (START) or back-to-back (CONT).
//
// Ports:
//   SYSCLK      in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   START       in   one-conversion request, sampled only in IDLE
//   CONT        in   keep converting back-to-back while high
//   adc         if   master side of ads8864_adc_ctrl_if (CNVST, SCLK, SDOUT)
//   DATA        out  last captured sample
//   DATA_VALID  out  one-cycle strobe, DATA updated in the same cycle
//   BUSY        out  high whenever the controller is not idle
//   TIMEOUT_ERR out  sticky busy-indicator timeout (0 without BUSY_IND_EN)
//
// Build option:
//   BUSY_IND_EN  when defined, the conversion wait ends on the first cycle
//                ADC_SDOUT reads 0 instead of after CONV_CYCLES; no 0 within
//                BUSY_TIMEOUT cycles sets TIMEOUT_ERR and returns to IDLE.
//
// All outputs are registered: next-state and counters are computed
// combinationally and the output registers load from the next state.
// -----------------------------------------------------------------------------
module ads8864_adc_ctrl #(
   parameter int unsigned SCLK_HALF       = 2,
   parameter int unsigned CNV_HIGH_CYCLES = 4,
   parameter int unsigned CONV_CYCLES     = 140,
   parameter int unsigned NBITS           = 16,
   parameter int unsigned BUSY_TIMEOUT    = 200
) (
   input  logic               SYSCLK,
   input  logic               RESET_N,
   input  logic               START,
   input  logic               CONT,
   ads8864_adc_ctrl_if.master adc,
   output logic [NBITS-1:0]   DATA,
   output logic               DATA_VALID,
   output logic               BUSY,
   output logic               TIMEOUT_ERR
);

   if (SCLK_HALF < 1 || CNV_HIGH_CYCLES < 2 || CONV_CYCLES < 1 ||
       BUSY_TIMEOUT < 1 || NBITS < 1) begin : g_bad_param
      $error("ads8864_adc_ctrl: illegal parameter value");
   end

`ifdef BUSY_IND_EN
   localparam int unsigned WAIT_MAX = BUSY_TIMEOUT;
`else
   localparam int unsigned WAIT_MAX = CONV_CYCLES;
`endif
   localparam int unsigned CNT_MAX = (WAIT_MAX > CNV_HIGH_CYCLES) ? WAIT_MAX : CNV_HIGH_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned HALF_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam int unsigned BIT_W   = $clog2(NBITS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNV,
      S_CONV,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [HALF_W-1:0]  r_half, w_half_nxt;
   logic [BIT_W-1:0]   r_bit, w_bit_nxt;
   logic               r_sclk, w_sclk_nxt;
   logic               w_sample;
   logic [NBITS:0]     r_shift;
   logic [NBITS-1:0]   r_data;
   logic               r_cnvst, w_cnvst_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_busy, w_busy_nxt;
   logic               w_unused_lead;
`ifdef BUSY_IND_EN
   logic               w_tmo_set;
   logic               r_tmo;
`endif

   // State register plus the counters and SCLK phase that belong to it.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_half  <= '0;
         r_bit   <= '0;
         r_sclk  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_half  <= w_half_nxt;
         r_bit   <= w_bit_nxt;
         r_sclk  <= w_sclk_nxt;
      end
   end

   // Next state. SCLK is itself the half-period phase: a low half ending
   // means a rising edge (sample point), a high half ending closes one bit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_half_nxt  = r_half;
      w_bit_nxt   = r_bit;
      w_sclk_nxt  = 1'b0;
      w_sample    = 1'b0;
`ifdef BUSY_IND_EN
      w_tmo_set   = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (START || CONT) begin
               w_state_nxt = S_CNV;
               w_cnt_nxt   = '0;
            end
         end
         S_CNV: begin
            if (r_cnt == CNT_W'(CNV_HIGH_CYCLES - 1)) begin
               w_state_nxt = S_CONV;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_CONV: begin
`ifdef BUSY_IND_EN
            if (!adc.ADC_SDOUT) begin
               w_state_nxt = S_SHIFT;
               w_half_nxt  = '0;
               w_bit_nxt   = '0;
            end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
               w_state_nxt = S_IDLE;
               w_tmo_set   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
`else
            if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
               w_state_nxt = S_SHIFT;
               w_half_nxt  = '0;
               w_bit_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
`endif
         end
         S_SHIFT: begin
            w_sclk_nxt = r_sclk;
            if (r_half == HALF_W'(SCLK_HALF - 1)) begin
               w_half_nxt = '0;
               w_sclk_nxt = ~r_sclk;
               if (!r_sclk) begin
                  w_sample = 1'b1;
               end else if (r_bit == BIT_W'(NBITS)) begin
                  w_state_nxt = S_DONE;
                  w_sclk_nxt  = 1'b0;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end else begin
               w_half_nxt = r_half + 1'b1;
            end
         end
         S_DONE: begin
            if (CONT) begin
               w_state_nxt = S_CNV;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      w_cnvst_nxt = (w_state_nxt == S_CNV);
      w_valid_nxt = (w_state_nxt == S_DONE);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnvst <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_shift <= '0;
         r_data  <= '0;
      end else begin
         r_cnvst <= w_cnvst_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         if (w_sample) begin
            r_shift <= {r_shift[NBITS-1:0], adc.ADC_SDOUT};
         end
         if (w_state_nxt == S_DONE) begin
            r_data <= r_shift[NBITS-1:0];
         end
      end
   end

   // The leading indicator bit is clocked in but never reported.
   assign w_unused_lead = r_shift[NBITS];

`ifdef BUSY_IND_EN
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_tmo <= 1'b0;
      end else if (w_tmo_set) begin
         r_tmo <= 1'b1;
      end
   end
   assign TIMEOUT_ERR = r_tmo;
`else
   assign TIMEOUT_ERR = 1'b0;
`endif

   assign adc.ADC_CNVST = r_cnvst;
   assign adc.ADC_SCLK  = r_sclk;
   assign DATA          = r_data;
   assign DATA_VALID    = r_valid;
   assign BUSY          = r_busy;

endmodule

// File: tb/tb_ads8864_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ads8864_adc_ctrl
// Self-checking bench for ads8864_adc_ctrl. A behavioural ADS8864 model
// answers each CNVST with a 17-bit word shifted out on SCLK; expected samples
// and timings come from the link rules (word[15:0], fixed latency and period).
// Build with BUSY_IND_EN defined to also cover the busy-indicator mode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ads8864_adc_ctrl;
   localparam int unsigned SCLK_HALF = 2;
   localparam int unsigned CNV_HIGH  = 4;
   localparam int unsigned CONV_CYC  = 140;
   localparam int unsigned NB        = 16;
   localparam int unsigned BTO       = 200;
   localparam int unsigned SHIFT_CYC = 2 * SCLK_HALF * (NB + 1);
   localparam int unsigned LAT       = 1 + CNV_HIGH + CONV_CYC + SHIFT_CYC;
   localparam int unsigned PERIOD    = CNV_HIGH + CONV_CYC + SHIFT_CYC + 1;

   logic          SYSCLK  = 1'b0;
   logic          RESET_N = 1'b1;
   logic          START   = 1'b0;
   logic          CONT    = 1'b0;
   logic [NB-1:0] DATA;
   logic          DATA_VALID;
   logic          BUSY;
   logic          TIMEOUT_ERR;

   ads8864_adc_ctrl_if adc_if();

   ads8864_adc_ctrl #(
      .SCLK_HALF       (SCLK_HALF),
      .CNV_HIGH_CYCLES (CNV_HIGH),
      .CONV_CYCLES     (CONV_CYC),
      .NBITS           (NB),
      .BUSY_TIMEOUT    (BTO)
   ) dut (
      .SYSCLK      (SYSCLK),
      .RESET_N     (RESET_N),
      .START       (START),
      .CONT        (CONT),
      .adc         (adc_if),
      .DATA        (DATA),
      .DATA_VALID  (DATA_VALID),
      .BUSY        (BUSY),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   always #5 SYSCLK = ~SYSCLK;

   int cyc = 0;
   always @(posedge SYSCLK) cyc++;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   // ---------------- behavioural ADC ----------------
   logic [16:0]  adc_word   = '0;  // word for the next conversion
   int           adc_mode   = 0;   // 0 fixed, 1 increment per conversion, 2 random
   logic [16:0]  tx         = '0;
   int           bitptr     = 16;
   int           rises      = 0;
   int           first_rise = -1;
   int           conv_entry = 0;
   int           busy_delay = CONV_CYC - 1;  // CONV cycle in which busy drops; <0 never
   int           cnv_rise_q[$];
   logic [15:0]  sent_q[$];
   logic         sdout = 1'b0;

   assign adc_if.ADC_SDOUT = sdout;

   always @(posedge adc_if.ADC_CNVST) begin
      cnv_rise_q.push_back(cyc);
      if (adc_mode == 2) adc_word = 17'($urandom);
      tx = adc_word;
      sent_q.push_back(tx[15:0]);
      if (adc_mode == 1) adc_word = adc_word + 17'd1;
      bitptr = 16;
`ifdef BUSY_IND_EN
      sdout = 1'b1;
`else
      sdout = tx[16];
`endif
   end

`ifdef BUSY_IND_EN
   always @(negedge adc_if.ADC_CNVST) begin
      if (RESET_N) begin
         conv_entry = cyc;
         if (busy_delay >= 0) begin
            repeat (busy_delay) @(posedge SYSCLK);
            #1 sdout = 1'b0;
            @(posedge SYSCLK);
            #1 sdout = tx[bitptr];
         end
      end
   end
`endif

   always @(posedge adc_if.ADC_SCLK) begin
      rises++;
      if (first_rise < 0) first_rise = cyc;
      bitptr--;
      #1 sdout = (bitptr >= 0) ? tx[bitptr] : 1'b0;
   end

   // ---------------- sequences ----------------
   task automatic run_single(input string name, input logic [16:0] w,
                             input logic [15:0] exp, input int exp_lat);
      int   n, hi;
      logic got;
      @(negedge SYSCLK);
      adc_word   = w;
      rises      = 0;
      first_rise = -1;
      START      = 1'b1;
      @(posedge SYSCLK);
      #1 START = 1'b0;
      n = 0; hi = 0; got = 1'b0;
      while (!got && n < 2 * LAT) begin
         @(negedge SYSCLK);
         n++;
         if (adc_if.ADC_CNVST) hi++;
         if (DATA_VALID) begin
            got = 1'b1;
            chk({name, " data"}, 32'(DATA), 32'(exp));
            chk({name, " latency"}, n, exp_lat);
         end
      end
      chk({name, " valid seen"}, 32'(got), 1);
      chk({name, " sclk rises"}, rises, NB + 1);
      chk({name, " cnvst high"}, hi, CNV_HIGH);
      @(negedge SYSCLK);
      chk({name, " valid pulse"}, 32'(DATA_VALID), 0);
      chk({name, " busy after"}, 32'(BUSY), 0);
   endtask

   // CONT held until 100 cycles into the last conversion, then dropped.
   task automatic run_cont(input string name, input int nconv,
                           input logic [16:0] w, input int mode);
      int          nvalid, last_v;
      logic [16:0] wk;
      logic [15:0] expd;
      @(negedge SYSCLK);
      adc_mode = mode;
      adc_word = w;
      cnv_rise_q.delete();
      sent_q.delete();
      nvalid = 0;
      last_v = 0;
      CONT   = 1'b1;
      for (int c = 0; c < (nconv + 2) * int'(PERIOD); c++) begin
         @(negedge SYSCLK);
         if (DATA_VALID) begin
            if (mode == 1) begin
               wk   = w + 17'(nvalid);
               expd = wk[15:0];
            end else begin
               expd = (sent_q.size() > 0) ? sent_q.pop_front() : 16'hxxxx;
            end
            chk($sformatf("%s data[%0d]", name, nvalid), 32'(DATA), 32'(expd));
            nvalid++;
            last_v = c;
         end
         if (CONT && nvalid == nconv - 1 && c == last_v + 100) CONT = 1'b0;
      end
      CONT = 1'b0;
      chk({name, " valid count"}, nvalid, nconv);
      chk({name, " cnvst count"}, cnv_rise_q.size(), nconv);
      for (int i = 1; i < cnv_rise_q.size(); i++)
         chk($sformatf("%s cnvst spacing[%0d]", name, i),
             cnv_rise_q[i] - cnv_rise_q[i-1], PERIOD);
      chk({name, " busy after"}, 32'(BUSY), 0);
      adc_mode = 0;
   endtask

   typedef struct {
      logic [16:0] word;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [16:0] rw;
      int          nv;
      logic [15:0] held;

      vecs[0] = '{17'h0ABCD, 16'hABCD};
      vecs[1] = '{17'h1FFFF, 16'hFFFF};
      vecs[2] = '{17'h10000, 16'h0000};
      vecs[3] = '{17'h15555, 16'h5555};
      vecs[4] = '{17'h0AAAA, 16'hAAAA};
      vecs[5] = '{17'h00001, 16'h0001};

      #1 RESET_N = 1'b0;
      repeat (3) @(negedge SYSCLK);
      chk("reset cnvst", 32'(adc_if.ADC_CNVST), 0);
      chk("reset sclk",  32'(adc_if.ADC_SCLK), 0);
      chk("reset data",  32'(DATA), 0);
      chk("reset valid", 32'(DATA_VALID), 0);
      chk("reset busy",  32'(BUSY), 0);
      chk("reset tmo",   32'(TIMEOUT_ERR), 0);
      RESET_N = 1'b1;
      repeat (2) @(negedge SYSCLK);

      // Single shots from the table.
      foreach (vecs[i])
         run_single($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp_data, LAT);

      // Continuous with an incrementing ADC; CONT dropped mid third conversion.
      run_cont("cont", 3, 17'h0ABCD, 1);

      // START pulses during CONV (cycle 51) and SHIFT (cycle 181) are ignored.
      @(negedge SYSCLK);
      adc_word = 17'h05A5A;
      cnv_rise_q.delete();
      START = 1'b1;
      @(posedge SYSCLK);
      #1 START = 1'b0;
      nv = 0;
      for (int c = 1; c <= 2 * int'(LAT); c++) begin
         @(negedge SYSCLK);
         START = (c == 50 || c == 180);
         if (DATA_VALID) nv++;
      end
      START = 1'b0;
      chk("ignore_start valids", nv, 1);
      chk("ignore_start cnvst", cnv_rise_q.size(), 1);
      chk("ignore_start data", 32'(DATA), 32'h5A5A);

      // Asynchronous reset in the middle of SHIFT.
      @(negedge SYSCLK);
      adc_word = 17'h1C3C3;
      START = 1'b1;
      @(posedge SYSCLK);
      #1 START = 1'b0;
      repeat (170) @(negedge SYSCLK);
      chk("midreset busy before", 32'(BUSY), 1);
      #2 RESET_N = 1'b0;
      #1;
      chk("midreset cnvst", 32'(adc_if.ADC_CNVST), 0);
      chk("midreset sclk",  32'(adc_if.ADC_SCLK), 0);
      chk("midreset busy",  32'(BUSY), 0);
      chk("midreset data",  32'(DATA), 0);
      chk("midreset valid", 32'(DATA_VALID), 0);
      repeat (3) @(negedge SYSCLK);
      RESET_N = 1'b1;
      repeat (2) @(negedge SYSCLK);
      run_single("after_reset", 17'h03C3C, 16'h3C3C, LAT);

      // Randomized single shots and a randomized continuous burst.
      for (int i = 0; i < 6; i++) begin
         rw = 17'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge SYSCLK);
         run_single($sformatf("rand%0d", i), rw, rw[15:0], LAT);
      end
      run_cont("rand_cont", 4, 17'h0, 2);

`ifdef BUSY_IND_EN
      // Busy indicator drops in CONV cycle 50.
      busy_delay = 50;
      run_single("busy50", 17'h0BEEF, 16'hBEEF, 1 + CNV_HIGH + 51 + SHIFT_CYC);
      chk("busy50 first rise", first_rise - conv_entry, 50 + 1 + SCLK_HALF);

      // Busy indicator never drops: timeout.
      busy_delay = -1;
      held = DATA;
      @(negedge SYSCLK);
      START = 1'b1;
      @(posedge SYSCLK);
      #1 START = 1'b0;
      nv = 0;
      for (int c = 0; c < 400 && !TIMEOUT_ERR; c++) begin
         @(negedge SYSCLK);
         if (DATA_VALID) nv++;
      end
      chk("tmo flag", 32'(TIMEOUT_ERR), 1);
      chk("tmo delay", cyc - conv_entry, BTO);
      chk("tmo busy", 32'(BUSY), 0);
      chk("tmo data held", 32'(DATA), 32'(held));
      repeat (20) @(negedge SYSCLK);
      chk("tmo no valid", nv + 32'(DATA_VALID), 0);
      chk("tmo sticky", 32'(TIMEOUT_ERR), 1);
      busy_delay = CONV_CYC - 1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
